// File: rtl/sn74_pkg.sv
// Shared constants for the '259-style addressable latch slice: slot
// addresses, address-source modes and the {clr_n, str} function codes.
package sn74_pkg;

  // Slot addresses, matching the output order a, b, c, d.
  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;
  localparam int unsigned NUM_SLOTS = 4;

  // Address source: external sel or the internal scan counter.
  localparam logic MODE_EXT  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  // Function code is the concatenation {clr_n, str}; both inputs are active-low.
  typedef enum logic [1:0] {
    FN_DEMUX  = 2'b00,  // addressed slot loads, others clear
    FN_CLEAR  = 2'b01,  // every slot clears
    FN_LATCH  = 2'b10,  // addressed slot loads, others hold
    FN_MEMORY = 2'b11   // every slot holds
  } fn_e;

  // Build the function code from the raw control pins.
  function automatic fn_e make_fn(input logic clr_n, input logic str);
    return fn_e'({clr_n, str});
  endfunction

  // Last address of a scan; a strobed edge here completes a frame.
  localparam logic [1:0] SCAN_LAST = SLOT_D;

endpackage

// File: rtl/sn74xx259_cell.sv
// One W-bit output slot of the addressable latch. It only knows whether it
// is the addressed slot (hit) and which function the edge performs.
module sn74xx259_cell
  import sn74_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hit,
  input  fn_e          fn,
  input  logic [W-1:0] in,
  output logic [W-1:0] q
);

  // Slot register: load, hold or clear according to the '259 function table.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      unique case (fn)
        FN_LATCH:  if (hit) q <= in;
        FN_DEMUX:  q <= hit ? in : '0;
        FN_CLEAR:  q <= '0;
        FN_MEMORY: q <= q;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/sn74xx259_dual.sv
// Receive end of a time-multiplexed bus: captures one W-bit sample per edge
// into slot a..d, addressed externally (sel) or by an internal scan counter
// that also drives the upstream 4:1 mux select. A completed scan of slot d
// raises frame for one cycle.
module sn74xx259_dual
  import sn74_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in,
  input  logic [1:0]   sel,
  input  logic         str,
  input  logic         clr_n,
  input  logic         mode,
  output logic [1:0]   scan,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         frame
);

  logic [1:0]           addr;
  fn_e                  fn;
  logic [NUM_SLOTS-1:0] hit;
  logic [W-1:0]         slot [NUM_SLOTS];
  logic                 scan_step;
  logic                 scan_done;

  // Address source select and function decode from the control pins.
  always_comb begin
    addr = (mode == MODE_SCAN) ? scan : sel;
    fn   = make_fn(clr_n, str);
  end

  // One-hot slot decode of the effective address.
  always_comb begin
    hit       = '0;
    hit[addr] = 1'b1;
  end

  // The scan advances only on strobed edges in scan mode; a strobed edge at
  // the last slot completes a frame whatever clr_n is doing.
  always_comb begin
    scan_step = (mode == MODE_SCAN) && !str;
    scan_done = scan_step && (scan == SCAN_LAST);
  end

  // Scan counter: parked at 0 in external mode so scanning always starts at
  // slot a; wraps 3 -> 0 through natural 2-bit overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan <= SLOT_A;
    end else if (mode == MODE_EXT) begin
      scan <= SLOT_A;
    end else if (scan_step) begin
      scan <= scan + 2'd1;
    end
  end

  // Frame pulse: visible in the same cycle as the slot-d write it marks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame <= 1'b0;
    end else begin
      frame <= scan_done;
    end
  end

  // Four identical slot registers, one per address.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    sn74xx259_cell #(.W(W)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .hit   (hit[i]),
      .fn    (fn),
      .in    (in),
      .q     (slot[i])
    );
  end

  assign a = slot[SLOT_A];
  assign b = slot[SLOT_B];
  assign c = slot[SLOT_C];
  assign d = slot[SLOT_D];

endmodule

// File: tb/tb_sn74xx259_dual.sv
// Directed bench for sn74xx259_dual with a modelled '153 upstream mux whose
// select is the DUT scan output. Expected values are hand-computed.
module tb_sn74xx259_dual;

  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in;
  logic [1:0]   sel;
  logic         str;
  logic         clr_n;
  logic         mode;
  logic [1:0]   scan;
  logic [W-1:0] a, b, c, d;
  logic         frame;

  // Upstream mux model: combinational from scan when enabled.
  logic         up_en;
  logic [W-1:0] up_src [4];
  logic [W-1:0] in_drv;

  int errors = 0;
  int checks = 0;

  sn74xx259_dual #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .sel   (sel),
    .str   (str),
    .clr_n (clr_n),
    .mode  (mode),
    .scan  (scan),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    in = up_en ? up_src[scan] : in_drv;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_slots(input string tag, input logic [7:0] exp);
    check(tag, {a, b, c, d}, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    up_en = 1'b0;
    up_src[0] = 2'd3; up_src[1] = 2'd2; up_src[2] = 2'd1; up_src[3] = 2'd0;
    in_drv = 2'd3; sel = 2'd0; str = 1'b0; clr_n = 1'b1; mode = 1'b1;

    // Reset held over several edges, scan mode and strobe active.
    for (int i = 0; i < 3; i++) begin
      step();
      check_slots("rst_slots", 8'h00);
      check("rst_scan", {6'd0, scan}, 8'd0);
      check("rst_frame", {7'd0, frame}, 8'd0);
    end
    mode = 1'b0;
    #2 rst_n = 1'b1;
    check_slots("rel_hold", 8'h00);
    step();
    check_slots("rel_first", {2'd3, 2'd0, 2'd0, 2'd0});

    // Auto-scan with upstream inputs 3,2,1,0.
    up_en = 1'b1; mode = 1'b1;
    step(); check("as1_scan", {6'd0, scan}, 8'd1); check("as1_frame", {7'd0, frame}, 8'd0);
    step(); check("as2_scan", {6'd0, scan}, 8'd2); check("as2_frame", {7'd0, frame}, 8'd0);
    step(); check("as3_scan", {6'd0, scan}, 8'd3); check("as3_frame", {7'd0, frame}, 8'd0);
    step(); check("as4_scan", {6'd0, scan}, 8'd0); check("as4_frame", {7'd0, frame}, 8'd1);
    check_slots("as4_slots", {2'd3, 2'd2, 2'd1, 2'd0});
    step(); check("as5_frame", {7'd0, frame}, 8'd0);
    step(); check("as6_frame", {7'd0, frame}, 8'd0);
    step(); check("as7_frame", {7'd0, frame}, 8'd0);
    step(); check("as8_frame", {7'd0, frame}, 8'd1);

    // External latch then memory.
    up_en = 1'b0; mode = 1'b0; sel = 2'd2; in_drv = 2'd1; str = 1'b0;
    step(); check_slots("ext_latch", {2'd3, 2'd2, 2'd1, 2'd0});
    check("ext_frame", {7'd0, frame}, 8'd0);
    // Distinguish from auto-scan leftovers: write a different value to c.
    in_drv = 2'd2; step(); check_slots("ext_latch2", {2'd3, 2'd2, 2'd2, 2'd0});
    str = 1'b1; in_drv = 2'd3; sel = 2'd0;
    step(); check_slots("memory", {2'd3, 2'd2, 2'd2, 2'd0});

    // Preload all slots to 3, then demux and clear.
    str = 1'b0; in_drv = 2'd3;
    for (int i = 0; i < 4; i++) begin
      sel = i[1:0];
      step();
    end
    check_slots("preload", 8'hff);
    clr_n = 1'b0; str = 1'b0; sel = 2'd1; in_drv = 2'd2;
    step(); check_slots("demux", {2'd0, 2'd2, 2'd0, 2'd0});
    str = 1'b1;
    step(); check_slots("clear", 8'h00);

    // Scan stall at scan=2, then resume through the wrap.
    up_src[0] = 2'd1; up_src[1] = 2'd2; up_src[2] = 2'd3; up_src[3] = 2'd1;
    up_en = 1'b1; clr_n = 1'b1; mode = 1'b1; str = 1'b0;
    step(); step();
    check("stall_pre", {6'd0, scan}, 8'd2);
    str = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_scan", {6'd0, scan}, 8'd2);
      check("stall_frame", {7'd0, frame}, 8'd0);
    end
    check_slots("stall_slots", {2'd1, 2'd2, 2'd0, 2'd0});
    str = 1'b0;
    step(); check("res_scan3", {6'd0, scan}, 8'd3); check("res_frame0", {7'd0, frame}, 8'd0);
    step(); check("res_scan0", {6'd0, scan}, 8'd0); check("res_frame1", {7'd0, frame}, 8'd1);
    check_slots("res_slots", {2'd1, 2'd2, 2'd3, 2'd1});

    // Mode 1 -> 0 at scan=1.
    step(); check("mid_scan1", {6'd0, scan}, 8'd1);
    up_en = 1'b0; mode = 1'b0; sel = 2'd0; in_drv = 2'd0;
    step(); check("msw_scan", {6'd0, scan}, 8'd0); check("msw_frame", {7'd0, frame}, 8'd0);

    // Reset asserted mid-scan at scan=3.
    up_en = 1'b1; mode = 1'b1;
    step(); step(); step();
    check("pre_rst_scan", {6'd0, scan}, 8'd3);
    #2 rst_n = 1'b0;
    #1;
    check_slots("async_slots", 8'h00);
    check("async_scan", {6'd0, scan}, 8'd0);
    step();
    #2 rst_n = 1'b1;
    step(); check("post_scan", {6'd0, scan}, 8'd1); check("post_frame1", {7'd0, frame}, 8'd0);
    step(); check("post_frame2", {7'd0, frame}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
